// File: rtl/mvprod_arbiter.sv
// Round-robin arbiter sharing one MVProd engine among NumReq requesters, routing chunk handshakes to the granted FIFOs.
// Optional RUN watchdog enabled by defining MVPROD_ARB_TIMEOUT_EN.
module mvprod_arbiter #(
  parameter int NumReq        = 2,
  parameter int ChunkBytes    = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NumReq-1:0]              req_valid,
  output logic [NumReq-1:0]              req_grant,
  output logic [NumReq-1:0]              req_done,
  output logic [NumReq-1:0]              req_rd_en,
  input  logic [NumReq*ChunkBytes*8-1:0] req_rd_data,
  output logic [NumReq-1:0]              req_ptr_rst,
  output logic [NumReq-1:0]              req_wr_en,
  output logic                           mv_in_data_ready,
  output logic [ChunkBytes*8-1:0]        mv_in_data,
  input  logic                           mv_req_chunk_in,
  input  logic                           mv_req_chunk_ptr_rst,
  input  logic                           mv_req_chunk_out,
  input  logic                           mv_out_vector_valid,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IW = $clog2(NumReq);
  localparam int DW = ChunkBytes * 8;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t            state_r, next_s;
  logic [NumReq-1:0] grant_r, done_r;
  logic [IW-1:0]     rr_ptr_r, gidx_r, pick_s, gnext_s;
  logic              ovv_q_r, start_r, busy_r, timeout_err_r;
  logic              complete_s, timeout_s, route_s;
  logic [DW-1:0]     mux_s;

  // First requesting index at or after ptr, wrapping around
  function automatic logic [IW-1:0] pick_next(input logic [NumReq-1:0] valid, input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    logic          hit;
    int            idx;
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(ptr) + i) % NumReq;
      if (!hit && valid[idx]) begin
        sel = IW'(idx);
        hit = 1'b1;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  assign pick_s     = pick_next(req_valid, rr_ptr_r);
  assign gnext_s    = (gidx_r == IW'(NumReq - 1)) ? '0 : gidx_r + IW'(1);
  assign complete_s = mv_out_vector_valid & ~ovv_q_r;

`ifdef MVPROD_ARB_TIMEOUT_EN
  logic [31:0] cnt_r;

  assign timeout_s = (state_r == RUN) && !complete_s && (cnt_r == 32'(TimeoutCycles - 1));

  // Watchdog counter: cleared on entry to RUN, counts every RUN cycle
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_r <= 32'd0;
    end else if (state_r == START) begin
      cnt_r <= 32'd0;
    end else if (state_r == RUN) begin
      cnt_r <= cnt_r + 32'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_valid) next_s = START;
        else            next_s = IDLE;
      end
      START: next_s = RUN;
      RUN: begin
        if (complete_s)     next_s = DONE;
        else if (timeout_s) next_s = IDLE;
        else                next_s = RUN;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Registered grant, pointer, pulses and status flags
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      grant_r       <= '0;
      gidx_r        <= '0;
      rr_ptr_r      <= '0;
      done_r        <= '0;
      ovv_q_r       <= 1'b0;
      start_r       <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      ovv_q_r <= mv_out_vector_valid;
      start_r <= (next_s == START);
      busy_r  <= (next_s != IDLE);
      done_r  <= ((state_r == RUN) && complete_s) ? grant_r : '0;
      if ((state_r == IDLE) && (|req_valid)) begin
        grant_r <= {{(NumReq-1){1'b0}}, 1'b1} << pick_s;
        gidx_r  <= pick_s;
      end else if ((state_r == DONE) || timeout_s) begin
        grant_r  <= '0;
        rr_ptr_r <= gnext_s;
      end else begin
        grant_r <= grant_r;
      end
      if (timeout_s) timeout_err_r <= 1'b1;
      else           timeout_err_r <= timeout_err_r;
    end
  end

  // Handshake routing to the granted FIFOs and chunk mux toward the engine
  always_comb begin
    route_s     = (state_r == START) || (state_r == RUN);
    req_rd_en   = '0;
    req_ptr_rst = '0;
    req_wr_en   = '0;
    mux_s       = '0;
    if (route_s) begin
      req_rd_en   = grant_r & {NumReq{mv_req_chunk_in}};
      req_ptr_rst = grant_r & {NumReq{mv_req_chunk_ptr_rst}};
      req_wr_en   = grant_r & {NumReq{mv_req_chunk_out}};
    end else begin
      req_rd_en   = '0;
    end
    for (int i = 0; i < NumReq; i++) begin
      if (grant_r[i]) mux_s = mux_s | req_rd_data[i*DW +: DW];
      else            mux_s = mux_s;
    end
  end

  assign req_grant        = grant_r;
  assign req_done         = done_r;
  assign mv_in_data_ready = start_r;
  assign mv_in_data       = mux_s;
  assign busy             = busy_r;
  assign timeout_err      = timeout_err_r;

endmodule
